// File: rtl/twiddle_fetch_ctrl.sv
// Twiddle ROM read sequencer: walks every stage/butterfly of one radix-2 FFT,
// hides the ROM read latency and streams complex twiddles through a 2-entry buffer.
module twiddle_fetch_ctrl #(
   parameter int N_STAGES       = 5,
   parameter int BFLY_PER_STAGE = 16,
   parameter int ADDR_W         = 5,
   parameter int DATA_W         = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_re_data,
   input  logic [DATA_W-1:0] rom_im_data,
   output logic              tw_valid,
   input  logic              tw_ready,
   output logic [DATA_W-1:0] tw_re,
   output logic [DATA_W-1:0] tw_im,
   output logic [2:0]        tw_stage,
   output logic              tw_last
);

   localparam int BW = (BFLY_PER_STAGE > 1) ? $clog2(BFLY_PER_STAGE) : 1;
   localparam logic [2:0]    LAST_STAGE = 3'(N_STAGES - 1);
   localparam logic [BW-1:0] LAST_BFLY  = BW'(BFLY_PER_STAGE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] re;
      logic [DATA_W-1:0] im;
      logic [2:0]        stage;
      logic              last;
   } entry_t;

   // Stage s owns 2^s entries at base 2^s-1; butterfly k wraps within them.
   function automatic logic [ADDR_W-1:0] bfly_addr(input logic [2:0] stage, input logic [BW-1:0] bfly);
      logic [ADDR_W-1:0] base;
      base = ADDR_W'((32'd1 << stage) - 32'd1);
      return base + (ADDR_W'(bfly) & base);
   endfunction

   state_t            state_r, state_s;
   logic [2:0]        stage_r, stage_s;
   logic [BW-1:0]     bfly_r, bfly_s;
   logic [ADDR_W-1:0] rom_addr_r, addr_s;
   logic              inflight_r, tag_last_r;
   logic [2:0]        tag_stage_r;
   logic [1:0]        occ_r, occ_s;
   logic              head_vld_r, busy_r, done_r;
   entry_t            head_r, tail_r, in_s;
   logic              issue_s, pop_s, last_issue_s, room_s;
   logic [2:0]        pend_s;

   // Issue decision, counter advance and next state.
   always_comb begin
      pop_s        = head_vld_r & tw_ready;
      pend_s       = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
      room_s       = (pend_s < 3'd2);
      last_issue_s = (stage_r == LAST_STAGE) && (bfly_r == LAST_BFLY);
      state_s      = state_r;
      stage_s      = stage_r;
      bfly_s       = bfly_r;
      addr_s       = rom_addr_r;
      issue_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = RUN;
               stage_s = 3'd0;
               bfly_s  = {BW{1'b0}};
               addr_s  = {ADDR_W{1'b0}};
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (room_s) begin
               issue_s = 1'b1;
               if (last_issue_s) begin
                  state_s = DRAIN;
               end else if (bfly_r == LAST_BFLY) begin
                  bfly_s  = {BW{1'b0}};
                  stage_s = stage_r + 3'd1;
                  addr_s  = bfly_addr(stage_r + 3'd1, {BW{1'b0}});
               end else begin
                  bfly_s  = bfly_r + {{(BW-1){1'b0}}, 1'b1};
                  addr_s  = bfly_addr(stage_r, bfly_r + {{(BW-1){1'b0}}, 1'b1});
               end
            end else begin
               issue_s = 1'b0;
            end
         end
         DRAIN: begin
            // The tagged-last entry is the only thing left once it is popped.
            if (pop_s && head_r.last) begin
               state_s = DONE;
            end else begin
               state_s = DRAIN;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Buffer occupancy update and incoming ROM word.
   always_comb begin
      in_s = '{re: rom_re_data, im: rom_im_data, stage: tag_stage_r, last: tag_last_r};
      case ({inflight_r, pop_s})
         2'b10:   occ_s = occ_r + 2'd1;
         2'b01:   occ_s = occ_r - 2'd1;
         default: occ_s = occ_r;
      endcase
   end

   // Sequencer state, counters, ROM address and tag pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         stage_r     <= 3'd0;
         bfly_r      <= {BW{1'b0}};
         rom_addr_r  <= {ADDR_W{1'b0}};
         inflight_r  <= 1'b0;
         tag_stage_r <= 3'd0;
         tag_last_r  <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r    <= state_s;
         stage_r    <= stage_s;
         bfly_r     <= bfly_s;
         rom_addr_r <= addr_s;
         inflight_r <= issue_s;
         if (issue_s) begin
            tag_stage_r <= stage_r;
            tag_last_r  <= last_issue_s;
         end
         busy_r <= (state_s == RUN) || (state_s == DRAIN);
         done_r <= (state_s == DONE);
      end
   end

   // Two-entry output buffer; head is kept in a fixed register so outputs come straight from flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_r     <= '0;
         tail_r     <= '0;
         occ_r      <= 2'd0;
         head_vld_r <= 1'b0;
      end else begin
         case ({inflight_r, pop_s})
            2'b10: begin
               if (occ_r == 2'd0) head_r <= in_s;
               else               tail_r <= in_s;
            end
            2'b01: begin
               if (occ_r == 2'd2) head_r <= tail_r;
            end
            2'b11: begin
               if (occ_r == 2'd2) begin
                  head_r <= tail_r;
                  tail_r <= in_s;
               end else begin
                  head_r <= in_s;
               end
            end
            default: ;
         endcase
         occ_r      <= occ_s;
         head_vld_r <= (occ_s != 2'd0);
      end
   end

   assign busy     = busy_r;
   assign done     = done_r;
   assign rom_addr = rom_addr_r;
   assign tw_valid = head_vld_r;
   assign tw_re    = head_r.re;
   assign tw_im    = head_r.im;
   assign tw_stage = head_r.stage;
   assign tw_last  = head_r.last;

endmodule

// File: tb/tb_twiddle_fetch_ctrl.sv
// Randomised bench for twiddle_fetch_ctrl: ROM model, reference twiddle order
// queued per transform, and a monitor that scores every handshake.
module tb_twiddle_fetch_ctrl;
   localparam int NS = 5;
   localparam int BPS = 16;
   localparam int AW = 5;
   localparam int DW = 16;
   localparam int TOTAL = NS * BPS;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          tw_ready = 1'b0;
   logic          busy, done, tw_valid, tw_last;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_re_data, rom_im_data, tw_re, tw_im;
   logic [2:0]    tw_stage;

   twiddle_fetch_ctrl #(.N_STAGES(NS), .BFLY_PER_STAGE(BPS), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .rom_addr(rom_addr), .rom_re_data(rom_re_data), .rom_im_data(rom_im_data),
      .tw_valid(tw_valid), .tw_ready(tw_ready), .tw_re(tw_re), .tw_im(tw_im),
      .tw_stage(tw_stage), .tw_last(tw_last));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   logic [DW-1:0] rom_re [2**AW];
   logic [DW-1:0] rom_im [2**AW];

   // Registered-read twiddle ROM pair.
   always @(posedge clk) begin
      rom_re_data <= rom_re[rom_addr];
      rom_im_data <= rom_im[rom_addr];
   end

   bit rdy_rand = 1'b0;
   always @(posedge clk) begin
      #1;
      if (rdy_rand) tw_ready = ($urandom_range(0, 99) < 30);
   end

   typedef struct {
      logic [DW-1:0] re;
      logic [DW-1:0] im;
      logic [2:0]    st;
      logic          last;
   } exp_t;
   exp_t exp_q[$];

   int checks = 0;
   int failures = 0;
   int run_xfers = 0;
   int done_cnt = 0;
   int last_hs_cyc = -10;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at cycle %0d: actual=%0h required=%0h", nm, cyc, act, req);
      end
   endtask

   // Reference order: stage-major, butterfly k reads (2^s-1) + k mod 2^s.
   task automatic push_model();
      for (int s = 0; s < NS; s++) begin
         for (int k = 0; k < BPS; k++) begin
            int a;
            exp_t e;
            a = (2**s - 1) + (k % (2**s));
            e.re = rom_re[a];
            e.im = rom_im[a];
            e.st = 3'(s);
            e.last = (s == NS - 1) && (k == BPS - 1);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic goto_neg(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
   endtask

   task automatic start_at(input int n, input bit accepted, output int t0);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
      start = 1'b1;
      t0 = cyc;
      if (accepted) push_model();
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done();
      int dc;
      int n;
      dc = done_cnt;
      n = 0;
      while (done_cnt == dc && n < 3000) begin
         @(posedge clk);
         n++;
      end
      chk("done_seen", 64'(done_cnt != dc), 64'(1));
      @(posedge clk);
      #1;
   endtask

   logic                stall_prev = 1'b0;
   logic [2*DW+3:0]     held;

   // Monitor: scores transfers, stall stability and the done pulse.
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (done) begin
            chk("done_xfers", 64'(run_xfers), 64'(TOTAL));
            chk("done_q_empty", 64'(exp_q.size()), 64'(0));
            chk("done_latency", 64'(cyc), 64'(last_hs_cyc + 1));
            chk("done_busy", 64'(busy), 64'(0));
            done_cnt++;
            run_xfers = 0;
         end
         if (stall_prev)
            chk("stall_hold", 64'({tw_valid, tw_re, tw_im, tw_stage, tw_last}), 64'({1'b1, held}));
         if (tw_valid && tw_ready) begin
            chk("xfer_avail", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
               exp_t e;
               e = exp_q.pop_front();
               chk("xfer", 64'({tw_re, tw_im, tw_stage, tw_last}), 64'({e.re, e.im, e.st, e.last}));
            end
            run_xfers++;
            if (tw_last) last_hs_cyc = cyc;
         end
         stall_prev = tw_valid && !tw_ready;
         held = {tw_re, tw_im, tw_stage, tw_last};
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int t1;
      int vcnt;
      int dc;
      int n;
      for (int a = 0; a < 2**AW; a++) begin
         rom_re[a] = {DW'($urandom_range(0, 2047)) << 5} | DW'(a);
         rom_im[a] = {DW'($urandom_range(0, 2047)) << 5} | DW'(a);
      end

      // Reset state
      goto_neg(1);
      chk("rst_ctrl", 64'({busy, done, tw_valid, tw_last, tw_stage, rom_addr}), 64'(0));
      chk("rst_data", 64'({tw_re, tw_im}), 64'(0));
      goto_neg(2);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic run with tw_ready held high
      tw_ready = 1'b1;
      start_at(10, 1'b1, t0);
      @(negedge clk);
      chk("first_busy_addr", 64'({busy, rom_addr, tw_valid}), 64'({1'b1, {AW{1'b0}}, 1'b0}));
      goto_neg(t0 + 2);
      chk("valid_not_early", 64'(tw_valid), 64'(0));
      vcnt = 0;
      for (int c = t0 + 3; c <= t0 + 82; c++) begin
         goto_neg(c);
         if (tw_valid) vcnt++;
         if (c == t0 + 82) chk("last_at_82", 64'(tw_last), 64'(1));
      end
      chk("valid_run", 64'(vcnt), 64'(TOTAL));
      goto_neg(t0 + 83);
      chk("done_at_83", 64'({done, busy, tw_valid}), 64'({1'b1, 1'b0, 1'b0}));
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;

      // Random 30% backpressure
      rdy_rand = 1'b1;
      start_at(cyc + 2, 1'b1, t0);
      wait_done();

      // Stalled from the start, then released
      rdy_rand = 1'b0;
      @(posedge clk);
      #2;
      tw_ready = 1'b0;
      start_at(cyc + 2, 1'b1, t0);
      for (int c = t0 + 3; c < t0 + 20; c++) begin
         goto_neg(c);
         chk("stall_head", 64'({tw_valid, tw_stage, tw_last, tw_re, tw_im}),
             64'({1'b1, 3'd0, 1'b0, rom_re[0], rom_im[0]}));
      end
      @(posedge clk);
      #1;
      tw_ready = 1'b1;
      wait_done();

      // start while busy is ignored
      start_at(cyc + 2, 1'b1, t0);
      start_at(t0 + 5, 1'b0, t1);
      dc = done_cnt;
      wait_done();
      repeat (40) @(posedge clk);
      #1;
      chk("single_done", 64'(done_cnt), 64'(dc + 1));

      // Reset after the 40th transfer
      rdy_rand = 1'b1;
      start_at(cyc + 2, 1'b1, t0);
      n = 0;
      while (run_xfers < 40 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      chk("reach_40", 64'(run_xfers), 64'(40));
      #1;
      rst = 1'b1;
      exp_q.delete();
      run_xfers = 0;
      dc = done_cnt;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_state", 64'({tw_valid, busy, done, tw_last, rom_addr}), 64'(0));
      repeat (30) @(posedge clk);
      #1;
      chk("midrst_no_done", 64'(done_cnt), 64'(dc));

      // Fresh transform after the reset
      start_at(cyc + 2, 1'b1, t0);
      wait_done();
      chk("final_q_empty", 64'(exp_q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/twiddle_fetch_ctrl.md
# twiddle_fetch_ctrl

Read-side sequencer for the FFT twiddle ROM pair, i.e. the real-part and imaginary-part ROMs sharing one address. It walks every radix-2 stage and butterfly of one transform and generates the ROM address for each butterfly. It absorbs the ROMs' one-cycle registered read latency and delivers each complex twiddle to the butterfly datapath over a valid/ready stream, with lossless backpressure through a 2-entry output buffer.

## Interface
- N_STAGES, 5, radix-2 stages per transform; requires 2^N_STAGES − 1 ≤ 2^ADDR_W
- BFLY_PER_STAGE, 16, butterflies per stage (N/2)
- ADDR_W, 5, ROM address width
- DATA_W, 16, twiddle component width (signed Q8.8)
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a transform when idle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the final twiddle handshake
- rom_addr  out  ADDR_W  address to both twiddle ROMs (registered)
- rom_re_data  in  DATA_W  real ROM output; valid the cycle after rom_addr was presented
- rom_im_data  in  DATA_W  imaginary ROM output; same timing as rom_re_data
- tw_valid  out  1  twiddle available
- tw_ready  in  1  consumer accepts; transfer occurs when tw_valid && tw_ready
- tw_re, tw_im  out  DATA_W  twiddle components
- tw_stage  out  3  stage index of the presented twiddle
- tw_last  out  1  high on the final twiddle of the transform

## Operation
- ROM layout: stage s uses 2^s contiguous entries starting at base 2^s − 1.
- Butterfly k of stage s: addr = (2^s − 1) + (k mod 2^s).
- Issue order: stage 0..N_STAGES−1; within each stage, k = 0..BFLY_PER_STAGE−1. Total 80 reads at the defaults.
- FSM states:
  - IDLE: on start → RUN, reset the stage and butterfly counters.
  - RUN: issues reads. After the last address is issued → DRAIN.
  - DRAIN: waits for the buffer and in-flight read to empty, with tw_last accepted → DONE.
  - DONE: asserts done for one cycle → IDLE.
- Issue rule, one read per cycle max: issue when (occupancy + inflight − pop) < 2.
  - inflight is a 1-bit register: a read was issued in the previous cycle.
  - pop = tw_valid && tw_ready.
  - This guarantees the buffer never overflows and sustains 1 twiddle/cycle while tw_ready stays high.
- Buffer: 2-entry FIFO of {re, im, stage, last}.
  - Written in the cycle inflight is high, capturing rom_re_data and rom_im_data.
  - Simultaneous push and pop is allowed at any occupancy ≥ 1.
  - The head drives the tw_* outputs.
- The stage and last tags travel with each read through a 1-stage tag pipeline aligned to ROM latency.
- start while busy, or in DONE, is ignored.
- tw_re, tw_im, tw_stage and tw_last hold their values while tw_valid && !tw_ready.

## Timing
- Reset (rst high at an edge):
  - State → IDLE; counters, inflight and FIFO cleared.
  - busy=0, done=0, tw_valid=0, tw_last=0, tw_stage=0, tw_re=0, tw_im=0, rom_addr=0.
  - Applies mid-transform as well: in-flight data is discarded, and no done pulse follows.
- start sampled high in cycle t (IDLE):
  - busy=1 and rom_addr=0 in cycle t+1.
  - ROM data valid in t+2.
  - tw_valid=1 in t+3 (first-twiddle latency 3).
- With tw_ready held high: tw_valid stays high continuously for 80 cycles, t+3..t+82; tw_last is high in t+82.
- done=1 and busy=0 in the cycle after the tw_last handshake. The FSM is in IDLE the following cycle, and a start there is accepted.
- rom_addr holds its last value when not issuing.

## Test plan
- Basic run, tw_ready=1:
  - start at cycle 10 → rom_addr=0 at cycle 11, tw_valid at 13.
  - Exactly 80 transfers, with tw_stage 0×16, 1×16, 2×16, 3×16, 4×16.
  - tw_last only on the 80th transfer; done at cycle 93.
- Address check: stage-2 reads issue 3,4,5,6,3,4,5,6,…; stage-4 reads issue 15..30. Transferred re/im equal ROM model contents at those addresses.
- Backpressure:
  - Random tw_ready at 30% duty → same 80-value sequence, no loss or duplication.
  - Outputs stable while stalled; at most 2 reads outstanding beyond consumed.
- tw_ready low from the start for 20 cycles → exactly 2 reads issued, tw_valid stays high with value from addr 0. Release → the remaining 78 follow in order.
- start pulsed at cycle t+5 while busy → ignored; still exactly 80 transfers and one done.
- rst asserted for 1 cycle after the 40th transfer:
  - Next cycle tw_valid=0, busy=0, rom_addr=0; no done pulse.
  - A subsequent start yields a full fresh 80-transfer sequence.
